ram_arbiter: RTL

//  Two-requester round-robin arbiter/sequencer in front of the single-port synchronous ram.

---
 rtl/ram_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter and sequencer in front of a single-port
// synchronous ram with one cycle of registered read latency.
//
// Each transaction latches one command. The arbiter drives a one-cycle ram
// strobe and a one-cycle ack to the requester that owns the transaction.
// For a read, the ram output is captured into rdata. A one-cycle rvalid
// pulse then goes to the owning requester.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req0/1, we0/1, addr0/1, wdata0/1 requester command inputs
//   ack0/1                           command accepted and issued (1 cycle)
//   rvalid0/1, rdata                 read return; rdata is shared, registered
//   busy                             FSM not in IDLE
//   mem_read_en, mem_write_en        ram strobes
//   mem_address_loc, mem_data_inbit  ram address and write data
//   mem_data_outbit                  ram read data
//
// Build option: define RAM_ARB_FIXED_PRIO_EN to make requester 0 always win
// when both request. The default build uses round-robin arbitration.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_BUS_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic                      req1,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ADDR_BUS_WIDTH-1:0] addr0,
  input  logic [ADDR_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]     wdata0,
  input  logic [DATA_WIDTH-1:0]     wdata1,
  output logic                      ack0,
  output logic                      ack1,
  output logic                      rvalid0,
  output logic                      rvalid1,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      busy,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  output logic [ADDR_BUS_WIDTH-1:0] mem_address_loc,
  output logic [DATA_WIDTH-1:0]     mem_data_inbit,
  input  logic [DATA_WIDTH-1:0]     mem_data_outbit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t                    state, state_d;
  logic                      gnt, gnt_d;      // owner of the current transaction
  logic                      pick;            // requester chosen in IDLE
  logic                      sel_we;
  logic [ADDR_BUS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_wdata;

  logic                      ack0_d, ack1_d, rvalid0_d, rvalid1_d, busy_d;
  logic                      rd_d, wr_d;
  logic [ADDR_BUS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]     wdata_d, rdata_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it requests.
  assign pick = ~req0;
`else
  logic last_gnt, last_gnt_d;

  // On contention, grant the requester that was not granted last.
  assign pick = (req0 & req1) ? ~last_gnt : ~req0;
  assign last_gnt_d = (state == IDLE && (req0 | req1)) ? pick : last_gnt;

  // Reset value 1 gives requester 0 the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_gnt <= 1'b1;
    else     last_gnt <= last_gnt_d;
  end
`endif

  assign sel_we    = pick ? we1    : we0;
  assign sel_addr  = pick ? addr1  : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, plus the register inputs that set up the outputs for the next cycle.
  always_comb begin
    state_d   = state;
    gnt_d     = gnt;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    addr_d    = mem_address_loc;
    wdata_d   = mem_data_inbit;
    rdata_d   = rdata;
    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ISSUE;
          gnt_d   = pick;
          ack0_d  = ~pick;
          ack1_d  = pick;
          wr_d    = sel_we;
          rd_d    = ~sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      // The registered read strobe records the direction of the latched command.
      ISSUE:   state_d = mem_read_en ? RDWAIT : IDLE;
      RDWAIT: begin
        state_d   = IDLE;
        rdata_d   = mem_data_outbit;
        rvalid0_d = ~gnt;
        rvalid1_d = gnt;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Output and command registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt             <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rvalid0         <= 1'b0;
      rvalid1         <= 1'b0;
      rdata           <= '0;
      busy            <= 1'b0;
      mem_read_en     <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_address_loc <= '0;
      mem_data_inbit  <= '0;
    end else begin
      gnt             <= gnt_d;
      ack0            <= ack0_d;
      ack1            <= ack1_d;
      rvalid0         <= rvalid0_d;
      rvalid1         <= rvalid1_d;
      rdata           <= rdata_d;
      busy            <= busy_d;
      mem_read_en     <= rd_d;
      mem_write_en    <= wr_d;
      mem_address_loc <= addr_d;
      mem_data_inbit  <= wdata_d;
    end
  end

endmodule
